// File: rtl/dnc_pkg.sv
// Shared definitions for the DNC accelerator matrix streaming endpoints.
//   rx_state_e  : receive-side FSM state encoding
//   DefaultMaxI : default buffer row capacity
//   DefaultMaxJ : default buffer column capacity
//   idx_width() : index width for a dimension, never narrower than one bit
package dnc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRequest,
    StWait,
    StDone
  } rx_state_e;

  localparam int unsigned DefaultMaxI = 8;
  localparam int unsigned DefaultMaxJ = 8;

  // $clog2(1) is 0, which would give zero-width index vectors.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accelerator_matrix_buffer.sv
// Row-major element store for the matrix receiver.
// Simple dual-port RAM of MaxI*MaxJ words, address = row*MaxJ + col.
//   clk_i, rst_ni        : clock, synchronous active-low reset (read regs only)
//   wr_en_i/wr_i_i/wr_j_i/wr_data_i : synchronous write port
//   rd_en_i/rd_i_i/rd_j_i           : read request
//   rd_data_o/rd_valid_o            : registered read result, one cycle later
// The storage array itself is never reset. A read and a write to the same
// address on the same edge return the pre-write contents.
module accelerator_matrix_buffer
  import dnc_pkg::*;
#(
  parameter int unsigned DataW = 64,
  parameter int unsigned MaxI  = DefaultMaxI,
  parameter int unsigned MaxJ  = DefaultMaxJ
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_en_i,
  input  logic [idx_width(MaxI)-1:0]  wr_i_i,
  input  logic [idx_width(MaxJ)-1:0]  wr_j_i,
  input  logic [DataW-1:0]            wr_data_i,
  input  logic                        rd_en_i,
  input  logic [idx_width(MaxI)-1:0]  rd_i_i,
  input  logic [idx_width(MaxJ)-1:0]  rd_j_i,
  output logic [DataW-1:0]            rd_data_o,
  output logic                        rd_valid_o
);

  localparam int unsigned Depth = MaxI * MaxJ;
  localparam int unsigned AddrW = idx_width(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_addr, rd_addr;
  logic [DataW-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    wr_addr = AddrW'(wr_i_i) * AddrW'(MaxJ) + AddrW'(wr_j_i);
    rd_addr = AddrW'(rd_i_i) * AddrW'(MaxJ) + AddrW'(rd_j_i);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr] <= wr_data_i;
    end
  end

  // Read data holds its last value while no read is requested.
  always_comb begin
    rd_valid_d = rd_en_i;
    rd_data_d  = rd_en_i ? mem_q[rd_addr] : rd_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/accelerator_matrix_receiver.sv
// Receive-side endpoint of the accelerator matrix streaming protocol.
// Requests elements one at a time, stores the producer's words row-major and
// pulses READY once the whole SIZE_I x SIZE_J matrix has been loaded.
//   CLK, RST (sync, active-low)
//   START, SIZE_I_IN, SIZE_J_IN        : transfer launch and dimensions
//   READY                              : one-cycle completion pulse
//   DATA_OUT_I_ENABLE/DATA_OUT_J_ENABLE: row / element request strobes
//   DATA_IN_I_ENABLE/DATA_IN_J_ENABLE/DATA_IN : producer row marker, strobe, word
//   ERROR                              : sticky size/protocol error
//   RD_ENABLE, RD_I, RD_J, RD_DATA, RD_VALID : independent buffer read port
module accelerator_matrix_receiver
  import dnc_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64,
  parameter int unsigned MAX_I        = DefaultMaxI,
  parameter int unsigned MAX_J        = DefaultMaxJ
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  output logic                         READY,
  input  logic [DATA_SIZE-1:0]         SIZE_I_IN,
  input  logic [DATA_SIZE-1:0]         SIZE_J_IN,
  output logic                         DATA_OUT_I_ENABLE,
  output logic                         DATA_OUT_J_ENABLE,
  input  logic                         DATA_IN_I_ENABLE,
  input  logic                         DATA_IN_J_ENABLE,
  input  logic [DATA_SIZE-1:0]         DATA_IN,
  output logic                         ERROR,
  input  logic                         RD_ENABLE,
  input  logic [idx_width(MAX_I)-1:0]  RD_I,
  input  logic [idx_width(MAX_J)-1:0]  RD_J,
  output logic [DATA_SIZE-1:0]         RD_DATA,
  output logic                         RD_VALID
);

  localparam int unsigned IdxIW = idx_width(MAX_I);
  localparam int unsigned IdxJW = idx_width(MAX_J);

  // CONTROL_SIZE is reserved for a future control sideband and has no logic.
  if (CONTROL_SIZE == 0) begin : g_no_control
  end

  rx_state_e        state_q, state_d;
  logic [IdxIW-1:0] i_q, i_d;
  logic [IdxJW-1:0] j_q, j_d;
  // Sizes are held as last valid index so the end-of-row/matrix tests are
  // plain equality compares on the counter width.
  logic [IdxIW-1:0] last_i_q, last_i_d;
  logic [IdxJW-1:0] last_j_q, last_j_d;
  logic             error_q, error_d;
  logic             ready_q, ready_d;

  logic             size_zero, size_over;
  logic             first_col, last_col, last_row;
  logic             wr_en;
  logic             req_i, req_j;

  always_comb begin
    // Full-width compares so an oversize value cannot alias into range.
    size_zero = (SIZE_I_IN == '0) || (SIZE_J_IN == '0);
    size_over = (SIZE_I_IN > DATA_SIZE'(MAX_I)) || (SIZE_J_IN > DATA_SIZE'(MAX_J));
    first_col = (j_q == '0);
    last_col  = (j_q == last_j_q);
    last_row  = (i_q == last_i_q);
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    last_i_d = last_i_q;
    last_j_d = last_j_q;
    error_d  = error_q;
    wr_en    = 1'b0;
    req_i    = 1'b0;
    req_j    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          i_d     = '0;
          j_d     = '0;
          error_d = 1'b0;
          if (size_zero) begin
            last_i_d = '0;
            last_j_d = '0;
            state_d  = StDone;
          end else if (size_over) begin
            last_i_d = '0;
            last_j_d = '0;
            error_d  = 1'b1;
            state_d  = StDone;
          end else begin
            last_i_d = IdxIW'(SIZE_I_IN - DATA_SIZE'(1));
            last_j_d = IdxJW'(SIZE_J_IN - DATA_SIZE'(1));
            state_d  = StRequest;
          end
        end
      end

      StRequest: begin
        req_j   = 1'b1;
        req_i   = first_col;
        state_d = StWait;
      end

      StWait: begin
        if (DATA_IN_J_ENABLE) begin
          wr_en = 1'b1;
          // The row marker must accompany exactly the column-0 element.
          if (DATA_IN_I_ENABLE != first_col) begin
            error_d = 1'b1;
          end
          if (last_col) begin
            j_d = '0;
            if (last_row) begin
              state_d = StDone;
            end else begin
              i_d     = i_q + IdxIW'(1);
              state_d = StRequest;
            end
          end else begin
            j_d     = j_q + IdxJW'(1);
            state_d = StRequest;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // READY trails the DONE state by one cycle.
    ready_d = (state_q == StDone);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      last_i_q <= '0;
      last_j_q <= '0;
      error_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      last_i_q <= last_i_d;
      last_j_q <= last_j_d;
      error_q  <= error_d;
      ready_q  <= ready_d;
    end
  end

  assign READY             = ready_q;
  assign ERROR             = error_q;
  assign DATA_OUT_I_ENABLE = req_i;
  assign DATA_OUT_J_ENABLE = req_j;

  accelerator_matrix_buffer #(
    .DataW (DATA_SIZE),
    .MaxI  (MAX_I),
    .MaxJ  (MAX_J)
  ) u_buffer (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .wr_en_i    (wr_en),
    .wr_i_i     (i_q),
    .wr_j_i     (j_q),
    .wr_data_i  (DATA_IN),
    .rd_en_i    (RD_ENABLE),
    .rd_i_i     (RD_I),
    .rd_j_i     (RD_J),
    .rd_data_o  (RD_DATA),
    .rd_valid_o (RD_VALID)
  );

endmodule

// File: tb/tb_accelerator_matrix_receiver.sv
module tb_accelerator_matrix_receiver;

  localparam int unsigned DW = 64;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic          READY;
  logic [DW-1:0] SIZE_I_IN = '0;
  logic [DW-1:0] SIZE_J_IN = '0;
  logic          DATA_OUT_I_ENABLE;
  logic          DATA_OUT_J_ENABLE;
  logic          DATA_IN_I_ENABLE = 1'b0;
  logic          DATA_IN_J_ENABLE = 1'b0;
  logic [DW-1:0] DATA_IN = '0;
  logic          ERROR;
  logic          RD_ENABLE = 1'b0;
  logic [2:0]    RD_I = '0;
  logic [2:0]    RD_J = '0;
  logic [DW-1:0] RD_DATA;
  logic          RD_VALID;

  // Reference model: expected buffer contents, filled as the producer sends.
  logic [DW-1:0] ref_mem [8][8];

  int n_total = 0;
  int n_pass  = 0;

  always #5 CLK = ~CLK;

  accelerator_matrix_receiver #(
    .DATA_SIZE    (64),
    .CONTROL_SIZE (64),
    .MAX_I        (8),
    .MAX_J        (8)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .START             (START),
    .READY             (READY),
    .SIZE_I_IN         (SIZE_I_IN),
    .SIZE_J_IN         (SIZE_J_IN),
    .DATA_OUT_I_ENABLE (DATA_OUT_I_ENABLE),
    .DATA_OUT_J_ENABLE (DATA_OUT_J_ENABLE),
    .DATA_IN_I_ENABLE  (DATA_IN_I_ENABLE),
    .DATA_IN_J_ENABLE  (DATA_IN_J_ENABLE),
    .DATA_IN           (DATA_IN),
    .ERROR             (ERROR),
    .RD_ENABLE         (RD_ENABLE),
    .RD_I              (RD_I),
    .RD_J              (RD_J),
    .RD_DATA           (RD_DATA),
    .RD_VALID          (RD_VALID)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Producer: answers each element request after 0..maxd idle cycles.
  // Element e goes to (e / sj, e % sj). bad_k flips the row marker on that
  // element; abort_at stops driving once that many elements were accepted.
  task automatic transfer(input logic [DW-1:0] si, input logic [DW-1:0] sj,
                          input int maxd, input bit spur, input bit seq_data,
                          input int bad_k, input int abort_at,
                          output int ready_cyc, output int n_ireq, output int n_jreq,
                          output int n_ibad, output int ready_after);
    int k, elem, wait_cnt, sj_i;
    bit pending;
    logic [DW-1:0] val;
    sj_i = int'(sj);
    ready_cyc = -1; n_ireq = 0; n_jreq = 0; n_ibad = 0; ready_after = 0;
    elem = 0; pending = 0; wait_cnt = 0;
    START = 1'b1; SIZE_I_IN = si; SIZE_J_IN = sj;
    step();
    k = 1;
    while (k < 600) begin
      START = 1'b0; DATA_IN_J_ENABLE = 1'b0; DATA_IN_I_ENABLE = 1'b0;
      if (abort_at >= 0 && elem == abort_at) break;
      if (READY) begin
        ready_cyc = k;
        break;
      end
      if (DATA_OUT_I_ENABLE && !DATA_OUT_J_ENABLE) n_ibad++;
      if (DATA_OUT_J_ENABLE) begin
        n_jreq++;
        if (DATA_OUT_I_ENABLE) n_ireq++;
        if (DATA_OUT_I_ENABLE !== ((elem % sj_i) == 0)) n_ibad++;
        pending = 1;
        wait_cnt = $urandom_range(maxd, 0);
        if (spur) begin
          // Strobes and a START in REQUEST must all be ignored.
          DATA_IN_J_ENABLE = 1'b1;
          DATA_IN_I_ENABLE = 1'($urandom);
          DATA_IN = {$urandom, $urandom};
          START = 1'b1;
          SIZE_I_IN = '0;
        end
      end else if (pending) begin
        if (wait_cnt == 0) begin
          val = seq_data ? DW'(16 + elem) : {$urandom, $urandom};
          ref_mem[elem / sj_i][elem % sj_i] = val;
          DATA_IN = val;
          DATA_IN_J_ENABLE = 1'b1;
          DATA_IN_I_ENABLE = ((elem % sj_i) == 0) ^ (elem == bad_k);
          pending = 0;
          elem++;
        end else begin
          wait_cnt--;
        end
      end
      step();
      k++;
    end
    START = 1'b0;
    if (ready_cyc >= 0) begin
      step();
      ready_after = int'(READY);
    end
  endtask

  task automatic read_chk(input int i, input int j, input logic [DW-1:0] exp, input string tag);
    RD_ENABLE = 1'b1; RD_I = 3'(i); RD_J = 3'(j);
    step();
    RD_ENABLE = 1'b0;
    check({tag, "_valid"}, DW'(RD_VALID), DW'(1));
    check(tag, RD_DATA, exp);
  endtask

  initial begin
    int rc, ni, nj, nb, ra, si, sj, nready;
    logic [DW-1:0] held;

    // Reset state
    RST = 1'b0;
    step(); step();
    check("rst_ready", DW'(READY), '0);
    check("rst_out_i", DW'(DATA_OUT_I_ENABLE), '0);
    check("rst_out_j", DW'(DATA_OUT_J_ENABLE), '0);
    check("rst_error", DW'(ERROR), '0);
    check("rst_rd_valid", DW'(RD_VALID), '0);
    check("rst_rd_data", RD_DATA, '0);
    RST = 1'b1;
    step();

    // 2x3, single-cycle producer, values 0x10..0x15
    transfer(2, 3, 0, 0, 1, -1, -1, rc, ni, nj, nb, ra);
    check("t1_ready_cycle", DW'(rc), DW'(14));
    check("t1_j_requests", DW'(nj), DW'(6));
    check("t1_i_requests", DW'(ni), DW'(2));
    check("t1_i_placement", DW'(nb), '0);
    check("t1_ready_pulse", DW'(ra), '0);
    check("t1_error", DW'(ERROR), '0);
    read_chk(1, 2, 64'h15, "t1_rd_1_2");
    for (int e = 0; e < 6; e++) read_chk(e / 3, e % 3, ref_mem[e / 3][e % 3], "t1_rd");
    held = RD_DATA;
    step();
    check("rd_valid_idle", DW'(RD_VALID), '0);
    check("rd_data_hold", RD_DATA, held);

    // Same shape, random delays, spurious strobes and START in REQUEST
    transfer(2, 3, 5, 1, 0, -1, -1, rc, ni, nj, nb, ra);
    check("t2_ready_seen", DW'(rc > 0), DW'(1));
    check("t2_j_requests", DW'(nj), DW'(6));
    check("t2_i_placement", DW'(nb), '0);
    check("t2_error", DW'(ERROR), '0);
    for (int e = 0; e < 6; e++) read_chk(e / 3, e % 3, ref_mem[e / 3][e % 3], "t2_rd");

    // Zero rows
    transfer(0, 4, 0, 0, 0, -1, -1, rc, ni, nj, nb, ra);
    check("zero_ready_cycle", DW'(rc), DW'(2));
    check("zero_j_requests", DW'(nj), '0);
    check("zero_error", DW'(ERROR), '0);

    // Oversize column count, then a valid START clears ERROR
    transfer(2, 9, 0, 0, 0, -1, -1, rc, ni, nj, nb, ra);
    check("over_ready_cycle", DW'(rc), DW'(2));
    check("over_j_requests", DW'(nj), '0);
    check("over_error", DW'(ERROR), DW'(1));
    read_chk(0, 0, ref_mem[0][0], "over_nothing_stored");
    transfer(64'h1_0000_0002, 2, 0, 0, 0, -1, -1, rc, ni, nj, nb, ra);
    check("over_wide_error", DW'(ERROR), DW'(1));
    check("over_wide_ready_cycle", DW'(rc), DW'(2));
    transfer(1, 1, 0, 0, 0, -1, -1, rc, ni, nj, nb, ra);
    check("clear_ready_cycle", DW'(rc), DW'(4));
    check("clear_error", DW'(ERROR), '0);
    read_chk(0, 0, ref_mem[0][0], "clear_rd");

    // Missing row marker on (1,0) of a 2x2
    transfer(2, 2, 0, 0, 0, 2, -1, rc, ni, nj, nb, ra);
    check("bad_ready_cycle", DW'(rc), DW'(10));
    check("bad_error", DW'(ERROR), DW'(1));
    read_chk(1, 0, ref_mem[1][0], "bad_stored");

    // Reset after 3 of 4 elements (with a marker error pending)
    transfer(2, 2, 0, 0, 0, 1, 3, rc, ni, nj, nb, ra);
    check("abort_no_ready", DW'(rc), DW'(-1));
    check("abort_error_before", DW'(ERROR), DW'(1));
    RST = 1'b0;
    step();
    check("abort_outputs", DW'({READY, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, ERROR, RD_VALID}),
          '0);
    check("abort_rd_data", RD_DATA, '0);
    RST = 1'b1;
    nready = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      nready += int'(READY) + int'(DATA_OUT_J_ENABLE);
    end
    check("abort_quiet", DW'(nready), '0);
    read_chk(1, 0, ref_mem[1][0], "abort_partial_kept");

    // Random shapes
    for (int t = 0; t < 3; t++) begin
      si = $urandom_range(8, 1);
      sj = $urandom_range(8, 1);
      transfer(DW'(si), DW'(sj), $urandom_range(2, 0), 0, 0, -1, -1, rc, ni, nj, nb, ra);
      check("rnd_ready_seen", DW'(rc > 0), DW'(1));
      check("rnd_j_requests", DW'(nj), DW'(si * sj));
      check("rnd_i_requests", DW'(ni), DW'(si));
      check("rnd_error", DW'(ERROR), '0);
      for (int e = 0; e < si * sj; e++) read_chk(e / sj, e % sj, ref_mem[e / sj][e % sj], "rnd_rd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/accelerator_matrix_receiver.md
# accelerator_matrix_receiver

Receive-side endpoint of the DNC accelerator matrix streaming protocol. The producer (testbench stimulus or upstream controller) supplies matrix elements on request; this block issues the row/element request strobes, accepts the producer's strobed data words, stores them row-major in an internal buffer and pulses READY when the full SIZE_I x SIZE_J matrix is loaded. It sits in front of the accelerator datapath as the W/K/U/B ingress loader, one instance per matrix operand.

## Interface
- DATA_SIZE, 64, data word and size-port width
- CONTROL_SIZE, 64, control width (reserved, unused)
- MAX_I, 8, maximum rows held in buffer
- MAX_J, 8, maximum columns held in buffer
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-low
- START  in  1  begin transfer; sizes sampled same cycle
- READY  out  1  one-cycle pulse at transfer completion
- SIZE_I_IN  in  DATA_SIZE  row count
- SIZE_J_IN  in  DATA_SIZE  column count
- DATA_OUT_I_ENABLE  out  1  row request pulse (with first element of each row)
- DATA_OUT_J_ENABLE  out  1  element request pulse
- DATA_IN_I_ENABLE  in  1  producer row marker, high with column-0 element
- DATA_IN_J_ENABLE  in  1  producer element strobe, DATA_IN valid
- DATA_IN  in  DATA_SIZE  element word
- ERROR  out  1  sticky protocol/size error, cleared on START
- RD_ENABLE  in  1  buffer read request
- RD_I  in  $clog2(MAX_I)  read row
- RD_J  in  $clog2(MAX_J)  read column
- RD_DATA  out  DATA_SIZE  read word
- RD_VALID  out  1  RD_DATA valid

## Operation
- States: IDLE, REQUEST, WAIT, DONE.
- IDLE: on START latch SIZE_I_IN/SIZE_J_IN, clear ERROR, i=j=0. Either size 0 -> DONE. SIZE_I_IN>MAX_I or SIZE_J_IN>MAX_J -> set ERROR, DONE, nothing stored. Else -> REQUEST.
- REQUEST (1 cycle): DATA_OUT_J_ENABLE=1; DATA_OUT_I_ENABLE=1 iff j==0. -> WAIT.
- WAIT: hold until DATA_IN_J_ENABLE=1; on that edge write DATA_IN at (i,j). If DATA_IN_I_ENABLE != (j==0) set ERROR, element still stored. Advance j; on j==SIZE_J-1 wrap j=0, i++. Last element (i==SIZE_I-1, j==SIZE_J-1) -> DONE, else -> REQUEST.
- DONE (1 cycle): READY=1. -> IDLE.
- START outside IDLE ignored. DATA_IN_*_ENABLE outside WAIT ignored, no error.
- Size compares in full DATA_SIZE width; counters $clog2 wide, no wrap beyond sizes.
- Read port independent of FSM, usable in any state; read of address written same cycle returns old contents. Out-of-range RD_I/RD_J return unspecified data, RD_VALID still asserted.

## Timing
- Reset (RST low at edge): state IDLE; READY, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, ERROR, RD_VALID, RD_DATA all 0; i, j, latched sizes 0. Buffer contents not cleared.
- Reset mid-transfer aborts; no READY; partial data remains in buffer.
- START at edge t -> REQUEST during cycle t+1 (first request strobes visible t+1).
- Producer responds earliest one cycle after request; minimum 2 cycles/element. Full matrix best case: READY in cycle 2*I*J+2 after START edge.
- Zero-size or oversize: READY in cycle t+2.
- Read: RD_ENABLE at edge t -> RD_DATA/RD_VALID valid cycle t+1; RD_VALID low when RD_ENABLE low, RD_DATA holds last value.

## Structure
- Shared package dnc_pkg: FSM state enum typedef, default MAX_I/MAX_J constants, index-width localparams.
- Sub-module accelerator_matrix_buffer: simple dual-port RAM, MAX_I*MAX_J x DATA_SIZE, address i*MAX_J+j, one synchronous write port, one registered read port. FSM, counters, error logic in top.

## Test plan
- 2x3 matrix, producer answers 1 cycle after each request, values 0x10..0x15 -> 6 J requests, I request on elements 0 and 3, READY at cycle 14 after START, reads (1,2)=0x15, ERROR=0.
- Same transfer with random 0-5 cycle producer delay and spurious DATA_IN_J_ENABLE in REQUEST -> identical buffer contents, spurious strobes ignored.
- SIZE_I_IN=0, SIZE_J_IN=4 -> no request strobes, READY 2 cycles after START, ERROR=0.
- SIZE_J_IN=9 with MAX_J=8 -> ERROR=1, READY 2 cycles after START; next valid START clears ERROR.
- DATA_IN_I_ENABLE low on element (1,0) of 2x2 -> ERROR=1, element stored, READY still pulses.
- RST low after 3 of 4 elements -> all outputs 0 next cycle, no READY; START during active transfer has no effect.
